// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: 32-cycle shift-add
// multiply or restoring divide on operand magnitudes, with sign fix-up at the end.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] r1_i,
    input  logic [31:0] r2_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_enable_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o,
    output logic        rd_enable_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic        r_rd_en;
    logic        r_neg;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [31:0] r_result;
    logic [4:0]  r_rd_o;
    logic        r_rd_en_o;
    logic        r_done;

    logic        w_r1_signed;
    logic        w_r2_signed;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_res_neg;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_special_val;
    logic [32:0] w_mul_sum;
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod_signed;
    logic [63:0] w_quo_signed;
    logic [63:0] w_rem_signed;
    logic [31:0] w_result;

    // Operand decode at accept: signedness, magnitudes, result sign and special cases.
    always_comb begin
        w_r1_signed   = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
                        (op_i == 3'b100) || (op_i == 3'b110);
        w_r2_signed   = (op_i == 3'b000) || (op_i == 3'b001) ||
                        (op_i == 3'b100) || (op_i == 3'b110);
        w_neg1        = w_r1_signed & r1_i[31];
        w_neg2        = w_r2_signed & r2_i[31];
        w_mag1        = w_neg1 ? (~r1_i + 32'd1) : r1_i;
        w_mag2        = w_neg2 ? (~r2_i + 32'd1) : r2_i;
        // Remainder takes the dividend's sign; products and quotients take the XOR.
        if ((op_i == 3'b110) || (op_i == 3'b111)) begin
            w_res_neg = w_neg1;
        end else begin
            w_res_neg = w_neg1 ^ w_neg2;
        end
        w_div_zero    = op_i[2] && (r2_i == 32'd0);
        w_div_ovf     = ((op_i == 3'b100) || (op_i == 3'b110)) &&
                        (r1_i == 32'h8000_0000) && (r2_i == 32'hFFFF_FFFF);
        w_special_val = 32'd0;
        case (op_i)
            3'b100, 3'b101: w_special_val = w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            3'b110, 3'b111: w_special_val = w_div_zero ? r1_i : 32'd0;
            default:        w_special_val = 32'd0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign/select.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + (r_a[0] ? {1'b0, r_b} : 33'd0);
        w_trial    = {r_acc[63:32], r_a[31]};
        w_diff     = w_trial - {1'b0, r_b};
        w_rem_next = w_diff[32] ? w_trial[31:0] : w_diff[31:0];
        if (r_op[2]) begin
            w_acc_next = {w_rem_next, r_acc[30:0], ~w_diff[32]};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[31:1]};
        end
        w_prod_signed = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;
        w_quo_signed  = r_neg ? (~{32'd0, w_acc_next[31:0]} + 64'd1) : {32'd0, w_acc_next[31:0]};
        w_rem_signed  = r_neg ? (~{32'd0, w_acc_next[63:32]} + 64'd1) : {32'd0, w_acc_next[63:32]};
        case (r_op)
            3'b000:                 w_result = w_prod_signed[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_signed[63:32];
            3'b100, 3'b101:         w_result = w_quo_signed[31:0];
            3'b110, 3'b111:         w_result = w_rem_signed[31:0];
            default:                w_result = 32'd0;
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_rd_en   <= 1'b0;
            r_neg     <= 1'b0;
            r_cnt     <= 5'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_acc     <= 64'd0;
            r_result  <= 32'd0;
            r_rd_o    <= 5'd0;
            r_rd_en_o <= 1'b0;
            r_done    <= 1'b0;
        end else if (flush_i) begin
            r_state   <= S_IDLE;
            r_rd_en_o <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rd_en_o <= 1'b0;
                    r_done    <= 1'b0;
                    if (start_i) begin
                        r_op    <= op_i;
                        r_rd_o  <= rd_i;
                        r_rd_en <= rd_enable_i;
                        r_neg   <= w_res_neg;
                        r_a     <= w_mag1;
                        r_b     <= w_mag2;
                        r_cnt   <= 5'd0;
                        r_acc   <= 64'd0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result  <= w_special_val;
                            r_rd_en_o <= rd_enable_i;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_op[2] ? {r_a[30:0], 1'b0} : {1'b0, r_a[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result  <= w_result;
                        r_rd_en_o <= r_rd_en;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state   <= S_CALC;
                    end
                end
                S_DONE: begin
                    r_rd_en_o <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_rd_en_o <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_req_o = !rst && (((r_state == S_IDLE) && start_i && !flush_i) ||
                                  (r_state == S_CALC));
    assign done_o      = r_done;
    assign result_o    = r_result;
    assign rd_o        = r_rd_o;
    assign rd_enable_o = r_rd_en_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus random ops
// against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] r1_i;
    logic [31:0] r2_i;
    logic [4:0]  rd_i;
    logic        rd_enable_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        rd_enable_o;

    int total = 0;
    int bad   = 0;

    ex_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .r1_i        (r1_i),
        .r2_i        (r2_i),
        .rd_i        (rd_i),
        .rd_enable_i (rd_enable_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .rd_o        (rd_o),
        .rd_enable_o (rd_enable_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, hold it like ID/EX would, and check latency, stall length and outputs.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic rden,
                         input logic [31:0] exp);
        int lat;
        int n_stall;
        int exp_lat;
        exp_lat = model_lat(op, a, b);
        lat     = 999;
        n_stall = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; r1_i = a; r2_i = b; rd_i = rd; rd_enable_i = rden;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (done_o === 1'b1) begin
                lat = c;
                break;
            end
            if (stall_req_o === 1'b1) n_stall++;
            @(negedge clk);
        end
        check({tag, ".lat"},   32'(lat),     32'(exp_lat));
        check({tag, ".stall"}, 32'(n_stall), 32'(exp_lat));
        check({tag, ".res"},   result_o,     exp);
        check({tag, ".rd"},    32'(rd_o),    32'(rd));
        check({tag, ".rden"},  32'(rd_enable_o), 32'(rden));
        check({tag, ".stall_done"}, 32'(stall_req_o), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start_i = 1'b1; op_i = 3'd0; r1_i = 32'd5; r2_i = 32'd3;
        rd_i = 5'd1; rd_enable_i = 1'b1; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.stall",  32'(stall_req_o), 32'd0);
        check("rst.done",   32'(done_o),      32'd0);
        check("rst.result", result_o,         32'd0);
        check("rst.rd",     32'(rd_o),        32'd0);
        check("rst.rden",   32'(rd_enable_o), 32'd0);
        rst = 1'b0; start_i = 1'b0;

        do_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  1'b1, 32'hFFFF_FFEB);
        do_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  1'b1, 32'h4000_0000);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  1'b1, 32'hFFFF_FFFE);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6,  1'b0, 32'hFFFF_FFFF);
        do_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  1'b1, 32'hFFFF_FFFD);
        do_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  1'b1, 32'hFFFF_FFFF);
        do_op("divu",   3'd5, 32'd100,        32'd7,         5'd9,  1'b1, 32'd14);
        do_op("remu",   3'd7, 32'd100,        32'd7,         5'd10, 1'b1, 32'd2);
        do_op("divu0",  3'd5, 32'd5,          32'd0,         5'd11, 1'b1, 32'hFFFF_FFFF);
        do_op("rem0",   3'd6, 32'd5,          32'd0,         5'd12, 1'b1, 32'd5);
        do_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000);
        do_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0);

        // Back-to-back MULs: second accepted in the IDLE cycle right after DONE.
        do_op("b2b1", 3'd0, 32'd12, 32'd11, 5'd20, 1'b1, 32'd132);
        do_op("b2b2", 3'd0, 32'd13, 32'd10, 5'd21, 1'b1, 32'd130);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("b2b.after_done", 32'(done_o),      32'd0);
        check("b2b.after_rden", 32'(rd_enable_o), 32'd0);

        // Flush at CALC cycle 10, then restart immediately.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; r1_i = 32'd1000; r2_i = 32'd3; rd_i = 5'd15; rd_enable_i = 1'b1;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        check("flush.stall", 32'(stall_req_o), 32'd0);
        check("flush.done",  32'(done_o),      32'd0);
        do_op("post_flush", 3'd5, 32'd1000, 32'd3, 5'd16, 1'b1, 32'd333);

        // Reset mid-CALC with start still asserted.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; r1_i = 32'd9; r2_i = 32'd9; rd_i = 5'd17; rd_enable_i = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.stall_now", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        check("midrst.stall",  32'(stall_req_o), 32'd0);
        check("midrst.done",   32'(done_o),      32'd0);
        check("midrst.result", result_o,         32'd0);
        check("midrst.rd",     32'(rd_o),        32'd0);
        check("midrst.rden",   32'(rd_enable_o), 32'd0);
        rst = 1'b0; start_i = 1'b0;

        // Random ops with corner-biased operands.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)), 1'b1, model(rop, ra, rb));
        end
        @(negedge clk);
        start_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
